// File: rtl/mdio_responder_if.sv
// mdio_responder_if: serial MDIO lines plus the register-file strobe bus of
// the PHY-side MDIO responder.
//   slave  : responder view (consumes mdc/mdio_out/mdio_oe/rd_data)
//   master : controller + register-file view
//   mdc, mdio_out, mdio_oe : management clock, serial data, driver enable
//   mdio_in                : serial read data back to the controller
//   addr, wr_data, wr_stb  : register write request
//   rd_stb, rd_data        : register read request and returned contents
//   mdio_done, frame_err   : end-of-frame / rejected-frame pulses
interface mdio_responder_if;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;

    logic              mdc;
    logic              mdio_out;
    logic              mdio_oe;
    logic              mdio_in;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_stb;
    logic              rd_stb;
    logic [DATA_W-1:0] rd_data;
    logic              mdio_done;
    logic              frame_err;

    modport slave (
        input  mdc, mdio_out, mdio_oe, rd_data,
        output mdio_in, addr, wr_data, wr_stb, rd_stb, mdio_done, frame_err
    );

    modport master (
        output mdc, mdio_out, mdio_oe, rd_data,
        input  mdio_in, addr, wr_data, wr_stb, rd_stb, mdio_done, frame_err
    );
endinterface

// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO responder. Samples mdc in the clk domain,
// deserializes 32-bit frames addressed to PHY_ADDR, issues one-clk write/read
// strobes to a local register file and shifts read data back on mdio_in.
// Ports:
//   clk   : system clock (mdc is derived from it by the controller)
//   reset : synchronous, active-high
//   bus   : mdio_responder_if.slave (serial lines + register strobe bus)
// Build option: define MDIO_PREAMBLE_EN to require 32 preamble ones before
// a start bit is accepted.
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR = 5'd3
) (
    input  logic            clk,
    input  logic            reset,
    mdio_responder_if.slave bus
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 6;

    localparam logic [CNT_W-1:0] BIT_ST   = 6'd2;
    localparam logic [CNT_W-1:0] BIT_OP   = 6'd4;
    localparam logic [CNT_W-1:0] BIT_HDR  = 6'd14;
    localparam logic [CNT_W-1:0] BIT_TA   = 6'd16;
    localparam logic [CNT_W-1:0] BIT_LAST = 6'd32;

    typedef enum logic [3:0] {
        IDLE, PRE, HDR, WTA, WDAT, RTA, RDAT, SKIP, ERR
    } state_t;

    state_t              state_q, state_d;
    logic                mdc_q;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                mdio_in_q, mdio_in_d;
    logic                wr_stb_q, wr_stb_d;
    logic                rd_stb_q, rd_stb_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                rise_c, fall_c;
    logic [CNT_W-1:0]    cnt_next_c;
    logic [DATA_W-1:0]   shift_in_c;

`ifdef MDIO_PREAMBLE_EN
    localparam logic [CNT_W-1:0] PRE_LEN = 6'd32;
    logic [CNT_W-1:0]    precnt_q, precnt_d;
`endif

    // mdc edge detection in the clk domain
    assign rise_c     = bus.mdc & ~mdc_q;
    assign fall_c     = ~bus.mdc & mdc_q;
    assign cnt_next_c = bitcnt_q + CNT_W'(1);
    assign shift_in_c = {shreg_q[DATA_W-2:0], bus.mdio_out};

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        mdio_in_d = 1'b0;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef MDIO_PREAMBLE_EN
        precnt_d  = '0;
`endif

        unique case (state_q)
            IDLE, PRE: begin
                bitcnt_d = '0;
`ifdef MDIO_PREAMBLE_EN
                // Count consecutive driven ones; a driven zero after a full
                // preamble is ST[1], otherwise it silently restarts the count.
                state_d  = PRE;
                precnt_d = precnt_q;
                if (rise_c) begin
                    if (!bus.mdio_oe) begin
                        precnt_d = '0;
                    end else if (bus.mdio_out) begin
                        if (precnt_q != PRE_LEN) begin
                            precnt_d = precnt_q + CNT_W'(1);
                        end
                    end else if (precnt_q == PRE_LEN) begin
                        shreg_d  = '0;
                        bitcnt_d = CNT_W'(1);
                        precnt_d = '0;
                        state_d  = HDR;
                    end else begin
                        precnt_d = '0;
                    end
                end
`else
                // First driven bit is ST[1]
                if (rise_c && bus.mdio_oe) begin
                    shreg_d  = {{(DATA_W-1){1'b0}}, bus.mdio_out};
                    bitcnt_d = CNT_W'(1);
                    state_d  = HDR;
                end
`endif
            end

            HDR: begin
                if (rise_c) begin
                    if (!bus.mdio_oe) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        shreg_d  = shift_in_c;
                        bitcnt_d = cnt_next_c;
                        if (cnt_next_c == BIT_ST && shift_in_c[1:0] != 2'b01) begin
                            err_d   = 1'b1;
                            state_d = ERR;
                        end else if (cnt_next_c == BIT_OP &&
                                     shift_in_c[1:0] != 2'b01 &&
                                     shift_in_c[1:0] != 2'b10) begin
                            err_d   = 1'b1;
                            state_d = ERR;
                        end else if (cnt_next_c == BIT_HDR) begin
                            // 14-bit header: [13:12] ST, [11:10] OP, [9:5] PHYAD, [4:0] REGAD
                            if (shift_in_c[9:5] != PHY_ADDR) begin
                                state_d = SKIP;
                            end else begin
                                addr_d = shift_in_c[4:0];
                                if (shift_in_c[11:10] == 2'b01) begin
                                    state_d = WTA;
                                end else begin
                                    rd_stb_d = 1'b1;
                                    state_d  = RTA;
                                end
                            end
                        end
                    end
                end
            end

            WTA: begin
                if (rise_c) begin
                    if (!bus.mdio_oe) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        shreg_d  = shift_in_c;
                        bitcnt_d = cnt_next_c;
                        if (cnt_next_c == BIT_TA) begin
                            if (shift_in_c[1:0] != 2'b10) begin
                                err_d   = 1'b1;
                                state_d = ERR;
                            end else begin
                                state_d = WDAT;
                            end
                        end
                    end
                end
            end

            WDAT: begin
                if (rise_c) begin
                    if (!bus.mdio_oe) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        shreg_d  = shift_in_c;
                        bitcnt_d = cnt_next_c;
                        if (cnt_next_c == BIT_LAST) begin
                            wr_data_d = shift_in_c;
                            wr_stb_d  = 1'b1;
                            done_d    = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
            end

            RTA: begin
                // Register file answers while rd_stb is high; capture at that edge
                if (rd_stb_q) begin
                    shreg_d = bus.rd_data;
                end
                if (rise_c) begin
                    bitcnt_d = cnt_next_c;
                    if (cnt_next_c == BIT_TA) begin
                        state_d = RDAT;
                    end
                end
            end

            RDAT: begin
                mdio_in_d = mdio_in_q;
                // Launch the next MSB on each fall so it is settled by the next rise
                if (fall_c) begin
                    mdio_in_d = shreg_q[DATA_W-1];
                    shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                end
                if (rise_c) begin
                    bitcnt_d = cnt_next_c;
                    if (cnt_next_c == BIT_LAST) begin
                        mdio_in_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end

            SKIP: begin
                if (rise_c) begin
                    bitcnt_d = cnt_next_c;
                    if (cnt_next_c == BIT_LAST) begin
                        state_d = IDLE;
                    end
                end
            end

            ERR: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        mdc_q <= bus.mdc;
        if (reset) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            mdio_in_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef MDIO_PREAMBLE_EN
            precnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            mdio_in_q <= mdio_in_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef MDIO_PREAMBLE_EN
            precnt_q  <= precnt_d;
`endif
        end
    end

    assign bus.mdio_in   = mdio_in_q;
    assign bus.addr      = addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_stb    = wr_stb_q;
    assign bus.rd_stb    = rd_stb_q;
    assign bus.mdio_done = done_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: drives MDIO frames into mdio_responder from a vector
// table plus hand-written corner-case sequences. Expected strobe/done/error
// events are queued as frames are sent and matched as the DUT pulses them;
// mdio_in is checked just before every mdc rise.
module tb_mdio_responder;
    localparam int unsigned HALF = 3;

    typedef enum logic [1:0] {VK_WRITE, VK_READ, VK_SKIP, VK_ERR} vk_t;

    typedef struct {
        logic [31:0] frame;
        int          oe_bits;
        logic [15:0] rdv;
        vk_t         kind;
        logic [4:0]  addr;
        logic [15:0] data;
        int          gap;
    } vec_t;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic        done;
        logic        err;
        logic [4:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic prev_pulse = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    vec_t vecs[10];
`ifdef MDIO_PREAMBLE_EN
    int   pre_len = 32;
`endif

    mdio_responder_if bus();

    mdio_responder #(.PHY_ADDR(5'd3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk_ev(input logic w, input logic r, input logic d,
                                  input logic e, input logic [4:0] a, input logic [15:0] dt);
        ev_t ev;
        ev = {w, r, d, e, a, dt};
        return ev;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One clk step; matches any pulse the DUT shows against the queue
    task automatic tick();
        ev_t e;
        logic any;
        logic ok;
        @(negedge clk);
        any = bus.wr_stb | bus.rd_stb | bus.mdio_done | bus.frame_err;
        if (any) begin
            check("pulse_not_back_to_back", 32'(prev_pulse), 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got wr=%b rd=%b done=%b err=%b addr=%h, expected none",
                         bus.wr_stb, bus.rd_stb, bus.mdio_done, bus.frame_err, bus.addr);
            end else begin
                e  = exp_q.pop_front();
                ok = (bus.wr_stb == e.wr) && (bus.rd_stb == e.rd) &&
                     (bus.mdio_done == e.done) && (bus.frame_err == e.err) &&
                     (!(e.wr || e.rd) || bus.addr == e.addr) &&
                     (!e.wr || bus.wr_data == e.data);
                if (!ok) begin
                    errors++;
                    $display("FAIL event: got wr=%b rd=%b done=%b err=%b addr=%h data=%h, expected wr=%b rd=%b done=%b err=%b addr=%h data=%h",
                             bus.wr_stb, bus.rd_stb, bus.mdio_done, bus.frame_err, bus.addr, bus.wr_data,
                             e.wr, e.rd, e.done, e.err, e.addr, e.data);
                end
            end
        end
        prev_pulse = any;
    endtask

    // One mdc period: set data while low, check mdio_in, then rise and fall
    task automatic mdc_cycle(input logic d, input logic oe, input logic exp_in, input string tag);
        bus.mdio_out = oe ? d : 1'b0;
        bus.mdio_oe  = oe;
        repeat (HALF) tick();
        check(tag, 32'(bus.mdio_in), 32'(exp_in));
        bus.mdc = 1'b1;
        repeat (HALF) tick();
        bus.mdc = 1'b0;
    endtask

    task automatic preamble();
`ifdef MDIO_PREAMBLE_EN
        for (int i = 0; i < pre_len; i++) mdc_cycle(1'b1, 1'b1, 1'b0, "mdio_in_pre");
`endif
    endtask

    task automatic drain(input int gap);
        for (int i = 0; i < gap; i++) mdc_cycle(1'b0, 1'b0, 1'b0, "mdio_in_idle");
        repeat (4) tick();
        check("pending_events", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_vec(input vec_t v);
        logic exp_in;
        bus.rd_data = v.rdv;
        case (v.kind)
            VK_WRITE: exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b1, 1'b0, v.addr, v.data));
            VK_READ: begin
                exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 1'b0, v.addr, 16'h0));
                exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, 1'b0, 5'h0, 16'h0));
            end
            VK_ERR:  exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 5'h0, 16'h0));
            default: ;
        endcase
        preamble();
        for (int k = 1; k <= 32; k++) begin
            exp_in = (v.kind == VK_READ && k >= 17) ? v.rdv[4'(32 - k)] : 1'b0;
            mdc_cycle(v.frame[5'(32 - k)], k <= v.oe_bits, exp_in, "mdio_in");
        end
        drain(v.gap);
    endtask

    initial begin
        logic [31:0] fr;
        vec_t        vq;

        vecs[0] = '{32'b01_01_00011_00101_10_1010101111001101, 32, 16'h0000, VK_WRITE, 5'd5,  16'hABCD, 2};
        vecs[1] = '{32'b01_10_00011_00111_00_0000000000000000, 14, 16'h1234, VK_READ,  5'd7,  16'h0000, 2};
        vecs[2] = '{32'b01_10_00100_00111_00_0000000000000000, 14, 16'h1234, VK_SKIP,  5'd0,  16'h0000, 2};
        vecs[3] = '{32'b01_01_00100_00001_10_1111111111111111, 32, 16'h0000, VK_SKIP,  5'd0,  16'h0000, 2};
        vecs[4] = '{32'b01_01_00011_00101_10_1010101111001101, 19, 16'h0000, VK_ERR,   5'd0,  16'h0000, 2};
        vecs[5] = '{32'b01_01_00011_00010_11_1111111111111111, 16, 16'h0000, VK_ERR,   5'd0,  16'h0000, 2};
        vecs[6] = '{32'b01_00_00011_00010_10_0000000000000000, 4,  16'h0000, VK_ERR,   5'd0,  16'h0000, 2};
        vecs[7] = '{32'b01_11_00011_00010_10_0000000000000000, 4,  16'h0000, VK_ERR,   5'd0,  16'h0000, 2};
        vecs[8] = '{32'b01_01_00011_11111_10_1000000000000001, 32, 16'h0000, VK_WRITE, 5'd31, 16'h8001, 0};
        vecs[9] = '{32'b01_10_00011_00000_00_0000000000000000, 14, 16'h8001, VK_READ,  5'd0,  16'h0000, 2};

        reset        = 1'b1;
        bus.mdc      = 1'b0;
        bus.mdio_out = 1'b0;
        bus.mdio_oe  = 1'b0;
        bus.rd_data  = 16'h0000;
        repeat (3) tick();
        check("reset_mdio_in",   32'(bus.mdio_in),   32'd0);
        check("reset_addr",      32'(bus.addr),      32'd0);
        check("reset_wr_data",   32'(bus.wr_data),   32'd0);
        check("reset_wr_stb",    32'(bus.wr_stb),    32'd0);
        check("reset_rd_stb",    32'(bus.rd_stb),    32'd0);
        check("reset_mdio_done", 32'(bus.mdio_done), 32'd0);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 10; i++) send_vec(vecs[i]);

`ifndef MDIO_PREAMBLE_EN
        // Bad ST: errors at stream bits 2, 6, 8, 10, 12, then a non-matching
        // header lands in SKIP and idle rises drain it.
        fr = 32'b11011111111001011001010001101111;
        for (int i = 0; i < 5; i++) exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b0, 1'b1, 5'h0, 16'h0));
        for (int k = 1; k <= 32; k++) begin
            mdc_cycle(fr[5'(32 - k)], 1'b1, 1'b0, "mdio_in_bad_st");
            if (k == 2) begin
                repeat (HALF) tick();
                check("first_err_after_bit2", 32'(exp_q.size()), 32'd4);
            end
        end
        drain(16);
        send_vec(vecs[0]);
`endif

        // Reset in the middle of a read while mdio_in is driving a one
        bus.rd_data = 16'hFFFF;
        fr = 32'b01_10_00011_01001_00_0000000000000000;
        exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 16'h0));
        preamble();
        for (int k = 1; k <= 24; k++)
            mdc_cycle(fr[5'(32 - k)], k <= 14, k >= 17, "mdio_in_pre_reset");
        repeat (HALF) tick();
        check("mdio_in_before_reset", 32'(bus.mdio_in), 32'd1);
        reset = 1'b1;
        tick();
        check("mdio_in_after_reset", 32'(bus.mdio_in), 32'd0);
        check("addr_after_reset",    32'(bus.addr),    32'd0);
        reset = 1'b0;
        for (int k = 25; k <= 32; k++) mdc_cycle(1'b0, 1'b0, 1'b0, "mdio_in_post_reset");
        drain(2);
        send_vec(vecs[8]);

`ifdef MDIO_PREAMBLE_EN
        vq      = vecs[0];
        vq.kind = VK_SKIP;
        pre_len = 31;
        send_vec(vq);
        pre_len = 32;
        send_vec(vecs[0]);
`else
        vq = vecs[1];
        send_vec(vq);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
